opb_register_bank_ppc2simulink: RTL and testbench
=================================================

OPB_REGISTER_BANK_PPC2SIMULINK -- requirements
Module: opb_register_bank_ppc2simulink

Interface
REQ-001 SHALL have parameter C_BASEADDR, default 32'h01100100, first byte address of the bank.
REQ-002 SHALL have parameter C_HIGHADDR, default 32'h011001FF, last byte address decoded.
REQ-003 SHALL have parameter C_OPB_AWIDTH, default 32, address width; C_OPB_DWIDTH, default 32, data width (only 32 supported).
REQ-004 SHALL have parameter C_NUM_REGS, default 4, number of writable registers, legal 1..16.
REQ-005 SHALL have parameter C_PULSE_MASK, default 0, width C_NUM_REGS; bit i=1 makes register i self-clearing.
REQ-006 SHALL have parameter C_FAMILY, default "virtex6", informational only.
REQ-007 One clock; reset is asynchronous and active-high: OPB_Clk in 1 (sole clock), OPB_Rst in 1 (async, active-high).
REQ-008 OPB_ABus in [0:31]: byte address; OPB_BE in [0:3]: byte enables, BE[0] = OPB_DBus[0:7].
REQ-009 OPB_DBus in [0:31]: write data; OPB_RNW in 1: 1=read; OPB_select in 1: transfer request; OPB_seqAddr in 1: unused.
REQ-010 Sl_DBus out [0:31]: read data; Sl_xferAck out 1: transfer acknowledge.
REQ-011 Sl_errAck, Sl_retry, Sl_toutSup out 1 each: tied 0.
REQ-012 user_data_out out [32*C_NUM_REGS-1:0]: register i on bits [32i+31:32i]; OPB bit 0 maps to bit 31.
REQ-013 user_wr_strb out [C_NUM_REGS-1:0]: one-cycle pulse per register update.

Function
REQ-014 Hit SHALL be OPB_select=1 and C_BASEADDR <= OPB_ABus <= C_HIGHADDR; word index = (OPB_ABus-C_BASEADDR)>>2, ABus low 2 bits ignored.
REQ-015 Map: index 0..C_NUM_REGS-1 = R/W registers; index C_NUM_REGS = read-only write counter; other in-range indices unmapped.
REQ-016 FSM SHALL have states IDLE and ACK; IDLE->ACK on edge where hit sampled; ACK->IDLE unconditionally next edge.
REQ-017 Hits sampled in ACK SHALL be ignored (no second transfer from one select assertion).
REQ-018 Sl_xferAck SHALL be 1 exactly during ACK (latency 1 cycle from sampled hit), 0 otherwise.
REQ-019 Sl_DBus SHALL be registered, carry read data only in ACK of a read, all-zero at all other times (OR-bus safe).
REQ-020 Write (RNW=0) to register i SHALL update, on IDLE->ACK edge, only bytes whose BE bit is 1; other bytes hold.
REQ-021 user_wr_strb[i] SHALL be 1 during ACK cycle of a write to register i with any BE bit set; else 0.
REQ-022 Register i with C_PULSE_MASK[i]=1 SHALL return to 0 on ACK->IDLE edge; new value visible exactly one cycle.
REQ-023 Write counter SHALL increment by 1 per write producing a strobe; wraps 32'hFFFFFFFF->0.
REQ-024 Read of register i SHALL return its current value; read of counter returns counter value at sampling edge.
REQ-025 Writes to counter or unmapped indices SHALL be acked, change nothing, raise no strobe; unmapped reads return 0.
REQ-026 Out-of-range addresses SHALL produce no ack, no update; bus timeout is master's responsibility.
REQ-027 Read transfers SHALL never modify any register, strobe or counter.
REQ-028 user_data_out SHALL be driven directly from registers (no extra pipeline stage).

Reset
REQ-029 OPB_Rst=1 SHALL immediately force: FSM IDLE, Sl_xferAck=0, Sl_DBus=0, all registers 0, user_wr_strb=0, counter=0.
REQ-030 Reset asserted during ACK SHALL abort transfer with no ack; transfer is not completed after release.
REQ-031 First hit SHALL be accepted on the first rising edge after OPB_Rst deasserts.

Verification
REQ-032 Write 32'hDEADBEEF, BE=4'b1111 to C_BASEADDR+4 -> next cycle xferAck=1, user_wr_strb=4'b0010, user_data_out[63:32]=32'hDEADBEEF, counter=1.
REQ-033 Then write 32'h12345678, BE=4'b0101 to same address -> bits[63:32]=32'hDE34BE78; read back returns 32'hDE34BE78 in ACK, Sl_DBus=0 one cycle later.
REQ-034 C_PULSE_MASK=4'b0001, write 32'h1 to register 0 -> user_data_out[31:0]=1 for one cycle then 0; read returns 0.
REQ-035 Select held high 3 cycles on one write -> exactly one ack, one strobe, counter +1; out-of-range address -> no ack for 16 cycles.
REQ-036 Preload counter path via 2^32 writes (force counter 32'hFFFFFFFF) then one write -> counter reads 0; write to counter index -> acked, value unchanged.
REQ-037 Assert OPB_Rst mid-ACK after writing 32'hFFFFFFFF to register 2 -> xferAck drops same cycle, all outputs 0, next hit acked one cycle after sampling.

Source files
------------

// File: rtl/opb_register_bank_ppc2simulink.sv
// OPB slave register bank bridging a PowerPC bus master to user (Simulink) logic.
//
// Word map, relative to C_BASEADDR:
//   index 0..C_NUM_REGS-1 : read/write registers with byte enables
//   index C_NUM_REGS      : read-only count of strobing writes
//   higher in-range index : acked, reads zero, writes ignored
//
// Ports:
//   OPB_Clk, OPB_Rst     sole clock; asynchronous active-high reset
//   OPB_ABus/BE/DBus     big-endian OPB address, byte enables, write data
//   OPB_RNW, OPB_select  transfer direction (1 = read) and request
//   OPB_seqAddr          unused
//   Sl_DBus, Sl_xferAck  registered read data (zero outside a read ack) and acknowledge
//   Sl_errAck/retry/toutSup  tied low
//   user_data_out        register i on bits [32i+31:32i], OPB bit 0 on bit 31
//   user_wr_strb         one-cycle pulse per register update
module opb_register_bank_ppc2simulink #(
  parameter int unsigned                 C_OPB_AWIDTH = 32,
  parameter int unsigned                 C_OPB_DWIDTH = 32,  // only 32 is supported
  parameter logic [C_OPB_AWIDTH-1:0]     C_BASEADDR   = 32'h0110_0100,
  parameter logic [C_OPB_AWIDTH-1:0]     C_HIGHADDR   = 32'h0110_01FF,
  parameter int unsigned                 C_NUM_REGS   = 4,
  parameter logic [C_NUM_REGS-1:0]       C_PULSE_MASK = '0,
  parameter string                       C_FAMILY     = "virtex6"
) (
  input  logic                           OPB_Clk,
  input  logic                           OPB_Rst,
  input  logic [0:C_OPB_AWIDTH-1]        OPB_ABus,
  input  logic [0:C_OPB_DWIDTH/8-1]      OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]        OPB_DBus,
  input  logic                           OPB_RNW,
  input  logic                           OPB_select,
  input  logic                           OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]        Sl_DBus,
  output logic                           Sl_xferAck,
  output logic                           Sl_errAck,
  output logic                           Sl_retry,
  output logic                           Sl_toutSup,
  output logic [32*C_NUM_REGS-1:0]       user_data_out,
  output logic [C_NUM_REGS-1:0]          user_wr_strb
);

  localparam int unsigned IdxW = C_OPB_AWIDTH - 2;
  localparam string unused_family = C_FAMILY;

  typedef enum logic [0:0] {StIdle, StAck} state_e;

  state_e                  state_q, state_d;
  logic                    held_q, held_d;
  logic [31:0]             regs_q [C_NUM_REGS];
  logic [31:0]             regs_d [C_NUM_REGS];
  logic [C_NUM_REGS-1:0]   strb_q, strb_d;
  logic [31:0]             cnt_q, cnt_d;
  logic [31:0]             dbus_q, dbus_d;

  logic [C_OPB_AWIDTH-1:0] addr;
  logic [C_OPB_AWIDTH-1:0] offset;
  logic [IdxW-1:0]         idx;
  logic [31:0]             wdata;
  logic [31:0]             rdata;
  logic                    in_range;
  logic                    hit;
  logic                    reg_sel;
  logic                    cnt_sel;

  // OPB bit 0 is the MSB, so plain assignment maps it onto bit 31.
  assign addr     = OPB_ABus;
  assign wdata    = OPB_DBus;
  assign offset   = addr - C_BASEADDR;
  assign idx      = offset[C_OPB_AWIDTH-1:2];
  assign in_range = (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
  // held_q blocks a second transfer while the master keeps select high after its ack.
  assign hit      = OPB_select && in_range && !held_q;
  assign reg_sel  = idx < IdxW'(C_NUM_REGS);
  assign cnt_sel  = idx == IdxW'(C_NUM_REGS);

  logic unused_inputs;
  assign unused_inputs = ^{OPB_seqAddr, offset[1:0]};

  always_comb begin
    rdata = '0;
    for (int i = 0; i < int'(C_NUM_REGS); i++) begin
      if (idx == IdxW'(i)) rdata = regs_q[i];
    end
    if (cnt_sel) rdata = cnt_q;
  end

  always_comb begin
    state_d = state_q;
    held_d  = held_q;
    regs_d  = regs_q;
    strb_d  = '0;
    cnt_d   = cnt_q;
    dbus_d  = '0;
    if (!OPB_select) held_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (hit) begin
          state_d = StAck;
          held_d  = 1'b1;
          if (OPB_RNW) begin
            dbus_d = rdata;
          end else if (reg_sel && (|OPB_BE)) begin
            cnt_d = cnt_q + 32'd1;
            for (int i = 0; i < int'(C_NUM_REGS); i++) begin
              if (idx == IdxW'(i)) begin
                strb_d[i] = 1'b1;
                for (int b = 0; b < 4; b++) begin
                  if (OPB_BE[b]) regs_d[i][31-8*b -: 8] = wdata[31-8*b -: 8];
                end
              end
            end
          end
        end
      end
      StAck: begin
        state_d = StIdle;
        for (int i = 0; i < int'(C_NUM_REGS); i++) begin
          if (C_PULSE_MASK[i]) regs_d[i] = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      state_q <= StIdle;
      held_q  <= 1'b0;
      strb_q  <= '0;
      cnt_q   <= '0;
      dbus_q  <= '0;
      for (int i = 0; i < int'(C_NUM_REGS); i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
      strb_q  <= strb_d;
      cnt_q   <= cnt_d;
      dbus_q  <= dbus_d;
      for (int i = 0; i < int'(C_NUM_REGS); i++) regs_q[i] <= regs_d[i];
    end
  end

  always_comb begin
    user_data_out = '0;
    for (int i = 0; i < int'(C_NUM_REGS); i++) user_data_out[32*i +: 32] = regs_q[i];
  end

  assign user_wr_strb = strb_q;
  assign Sl_xferAck   = (state_q == StAck);
  assign Sl_DBus      = dbus_q;
  assign Sl_errAck    = 1'b0;
  assign Sl_retry     = 1'b0;
  assign Sl_toutSup   = 1'b0;

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// Randomized and directed bench for opb_register_bank_ppc2simulink with a word-level model.
module tb_opb_register_bank_ppc2simulink;

  localparam logic [31:0] Base      = 32'h0110_0100;
  localparam logic [31:0] High      = 32'h0110_01FF;
  localparam logic [3:0]  PulseMask = 4'b0001;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [0:31]  abus = '0;
  logic [0:3]   be = '0;
  logic [0:31]  dbus = '0;
  logic         rnw = 1'b0;
  logic         sel = 1'b0;
  logic         seqaddr = 1'b0;
  logic [0:31]  sl_dbus;
  logic         ack, err, retry, tout;
  logic [127:0] udo;
  logic [3:0]   strb;

  int n_cmp = 0;
  int n_fail = 0;

  logic [31:0] m_reg [4];
  logic [31:0] m_cnt;

  always #5 clk = ~clk;

  opb_register_bank_ppc2simulink #(
    .C_PULSE_MASK(PulseMask)
  ) dut (
    .OPB_Clk      (clk),
    .OPB_Rst      (rst),
    .OPB_ABus     (abus),
    .OPB_BE       (be),
    .OPB_DBus     (dbus),
    .OPB_RNW      (rnw),
    .OPB_select   (sel),
    .OPB_seqAddr  (seqaddr),
    .Sl_DBus      (sl_dbus),
    .Sl_xferAck   (ack),
    .Sl_errAck    (err),
    .Sl_retry     (retry),
    .Sl_toutSup   (tout),
    .user_data_out(udo),
    .user_wr_strb (strb)
  );

  function automatic logic [127:0] model_udo();
    return {m_reg[3], m_reg[2], m_reg[1], m_reg[0]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_reg[i] = '0;
    m_cnt = '0;
  endtask

  // Word-level view of one transfer: what the master should see, and the state afterwards.
  task automatic model_apply(input logic [31:0] addr, input logic r, input logic [31:0] wd,
                             input logic [0:3] b, output logic e_ack, output logic [31:0] e_rd,
                             output logic [3:0] e_st, output logic [127:0] e_udo_ack);
    logic [31:0] mask;
    int unsigned widx;
    e_ack = (addr >= Base) && (addr <= High);
    e_rd  = '0;
    e_st  = '0;
    if (e_ack) begin
      widx = (addr - Base) / 4;
      mask = {{8{b[0]}}, {8{b[1]}}, {8{b[2]}}, {8{b[3]}}};
      if (r) begin
        if (widx < 4) e_rd = m_reg[widx];
        else if (widx == 4) e_rd = m_cnt;
      end else if (widx < 4 && mask != 0) begin
        m_reg[widx] = (m_reg[widx] & ~mask) | (wd & mask);
        e_st = 4'(1 << widx);
        m_cnt = m_cnt + 1;
      end
    end
    e_udo_ack = model_udo();
    for (int i = 0; i < 4; i++) if (PulseMask[i]) m_reg[i] = '0;
  endtask

  // Drives one transfer, waits a bounded number of cycles for the ack, drops select after it.
  task automatic bus_op(input logic [31:0] addr, input logic r, input logic [31:0] wd,
                        input logic [0:3] b, input int max_wait, output logic got_ack,
                        output logic [31:0] rd, output logic [3:0] st, output logic [127:0] u);
    @(negedge clk);
    abus = addr; rnw = r; dbus = wd; be = b; sel = 1'b1;
    got_ack = 1'b0; rd = '0; st = '0; u = udo;
    for (int k = 0; k < max_wait; k++) begin
      @(negedge clk);
      st = st | strb;
      if (ack === 1'b1) begin
        got_ack = 1'b1; rd = sl_dbus; u = udo;
        break;
      end
    end
    sel = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (ack !== 1'b0) begin n_fail++; $display("FAIL rst_ack: got %b want 0", ack); end
    n_cmp++; if (sl_dbus !== 32'h0) begin n_fail++; $display("FAIL rst_dbus: got %h want 0", sl_dbus); end
    n_cmp++; if (udo !== 128'h0) begin n_fail++; $display("FAIL rst_udo: got %h want 0", udo); end
    n_cmp++; if (strb !== 4'h0) begin n_fail++; $display("FAIL rst_strb: got %b want 0", strb); end
    n_cmp++; if ({err, retry, tout} !== 3'b000) begin
      n_fail++; $display("FAIL rst_tied: got %b want 000", {err, retry, tout});
    end
    // Hit presented together with reset release must be taken on the very next edge.
    abus = Base + 16; rnw = 1'b1; be = 4'hF; sel = 1'b1; rst = 1'b0;
    @(negedge clk);
    rd = sl_dbus;
    n_cmp++; if (ack !== 1'b1) begin n_fail++; $display("FAIL rst_first_hit: got %b want 1", ack); end
    n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL rst_cnt_read: got %h want 0", rd); end
    sel = 1'b0;
    model_reset();
  endtask

  task automatic test_byte_enables();
    logic a, ea; logic [31:0] rd, erd; logic [3:0] st, est; logic [127:0] u, eu;
    bus_op(Base + 4, 1'b0, 32'hDEAD_BEEF, 4'b1111, 4, a, rd, st, u);
    model_apply(Base + 4, 1'b0, 32'hDEAD_BEEF, 4'b1111, ea, erd, est, eu);
    n_cmp++; if (a !== 1'b1) begin n_fail++; $display("FAIL be_full_ack: got %b want 1", a); end
    n_cmp++; if (st !== 4'b0010) begin n_fail++; $display("FAIL be_full_strb: got %b want 0010", st); end
    n_cmp++; if (u[63:32] !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL be_full_data: got %h want deadbeef", u[63:32]);
    end
    bus_op(Base + 16, 1'b1, 32'h0, 4'hF, 4, a, rd, st, u);
    n_cmp++; if (rd !== 32'd1) begin n_fail++; $display("FAIL be_cnt1: got %h want 1", rd); end
    bus_op(Base + 4, 1'b0, 32'h1234_5678, 4'b0101, 4, a, rd, st, u);
    model_apply(Base + 4, 1'b0, 32'h1234_5678, 4'b0101, ea, erd, est, eu);
    n_cmp++; if (u !== eu) begin n_fail++; $display("FAIL be_partial_udo: got %h want %h", u, eu); end
    n_cmp++; if (u[63:32] !== 32'hDE34_BE78) begin
      n_fail++; $display("FAIL be_partial_data: got %h want de34be78", u[63:32]);
    end
    bus_op(Base + 4, 1'b1, 32'h0, 4'hF, 4, a, rd, st, u);
    n_cmp++; if (rd !== 32'hDE34_BE78) begin n_fail++; $display("FAIL be_readback: got %h want de34be78", rd); end
    n_cmp++; if (st !== 4'h0) begin n_fail++; $display("FAIL be_read_strb: got %b want 0", st); end
    @(negedge clk);
    n_cmp++; if (sl_dbus !== 32'h0) begin n_fail++; $display("FAIL be_dbus_idle: got %h want 0", sl_dbus); end
  endtask

  task automatic test_pulse();
    logic a, ea; logic [31:0] rd, erd; logic [3:0] st, est; logic [127:0] u, eu;
    bus_op(Base, 1'b0, 32'h1, 4'hF, 4, a, rd, st, u);
    model_apply(Base, 1'b0, 32'h1, 4'hF, ea, erd, est, eu);
    n_cmp++; if (u[31:0] !== 32'h1) begin n_fail++; $display("FAIL pulse_high: got %h want 1", u[31:0]); end
    @(negedge clk);
    n_cmp++; if (udo[31:0] !== 32'h0) begin n_fail++; $display("FAIL pulse_clear: got %h want 0", udo[31:0]); end
    bus_op(Base, 1'b1, 32'h0, 4'hF, 4, a, rd, st, u);
    n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL pulse_read: got %h want 0", rd); end
  endtask

  task automatic test_held_select();
    int acks = 0; int strbs = 0;
    logic a, ea; logic [31:0] rd, erd, wd; logic [3:0] st, est; logic [127:0] u, eu;
    wd = $urandom;
    @(negedge clk);
    abus = Base + 8; rnw = 1'b0; dbus = wd; be = 4'hF; sel = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (ack === 1'b1) acks++;
      if (strb !== 4'h0) strbs++;
      if (k == 2) sel = 1'b0;
    end
    model_apply(Base + 8, 1'b0, wd, 4'hF, ea, erd, est, eu);
    n_cmp++; if (acks !== 1) begin n_fail++; $display("FAIL held_acks: got %0d want 1", acks); end
    n_cmp++; if (strbs !== 1) begin n_fail++; $display("FAIL held_strbs: got %0d want 1", strbs); end
    bus_op(Base + 16, 1'b1, 32'h0, 4'hF, 4, a, rd, st, u);
    n_cmp++; if (rd !== m_cnt) begin n_fail++; $display("FAIL held_cnt: got %h want %h", rd, m_cnt); end
  endtask

  task automatic test_out_of_range();
    logic a; logic [31:0] rd; logic [3:0] st; logic [127:0] u;
    logic [31:0] addrs [2];
    addrs[0] = High + 1;
    addrs[1] = Base - 4;
    for (int j = 0; j < 2; j++) begin
      bus_op(addrs[j], 1'b0, 32'hFFFF_FFFF, 4'hF, 16, a, rd, st, u);
      n_cmp++; if (a !== 1'b0) begin n_fail++; $display("FAIL oor_ack %h: got %b want 0", addrs[j], a); end
      n_cmp++; if (st !== 4'h0) begin n_fail++; $display("FAIL oor_strb %h: got %b want 0", addrs[j], st); end
      n_cmp++; if (udo !== model_udo()) begin
        n_fail++; $display("FAIL oor_udo %h: got %h want %h", addrs[j], udo, model_udo());
      end
    end
  endtask

  task automatic test_counter_wrap();
    logic a, ea; logic [31:0] rd, erd; logic [3:0] st, est; logic [127:0] u, eu;
    @(negedge clk);
    force dut.cnt_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.cnt_q;
    m_cnt = 32'hFFFF_FFFF;
    bus_op(Base + 12, 1'b0, 32'hA5A5_5A5A, 4'hF, 4, a, rd, st, u);
    model_apply(Base + 12, 1'b0, 32'hA5A5_5A5A, 4'hF, ea, erd, est, eu);
    bus_op(Base + 16, 1'b1, 32'h0, 4'hF, 4, a, rd, st, u);
    n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL cnt_wrap: got %h want 0", rd); end
    bus_op(Base + 16, 1'b0, 32'h1234_0000, 4'hF, 4, a, rd, st, u);
    n_cmp++; if (a !== 1'b1) begin n_fail++; $display("FAIL cnt_wr_ack: got %b want 1", a); end
    n_cmp++; if (st !== 4'h0) begin n_fail++; $display("FAIL cnt_wr_strb: got %b want 0", st); end
    bus_op(Base + 16, 1'b1, 32'h0, 4'hF, 4, a, rd, st, u);
    n_cmp++; if (rd !== m_cnt) begin n_fail++; $display("FAIL cnt_wr_keep: got %h want %h", rd, m_cnt); end
  endtask

  task automatic test_reset_mid_ack();
    logic a, ea; logic [31:0] rd, erd; logic [3:0] st, est; logic [127:0] u, eu;
    @(negedge clk);
    abus = Base + 8; rnw = 1'b0; dbus = 32'hFFFF_FFFF; be = 4'hF; sel = 1'b1;
    @(posedge clk);
    #2;
    n_cmp++; if (ack !== 1'b1) begin n_fail++; $display("FAIL mid_ack_pre: got %b want 1", ack); end
    rst = 1'b1;
    #1;
    n_cmp++; if (ack !== 1'b0) begin n_fail++; $display("FAIL mid_ack_drop: got %b want 0", ack); end
    n_cmp++; if ({sl_dbus, strb} !== 36'h0) begin
      n_fail++; $display("FAIL mid_ack_outs: got %h want 0", {sl_dbus, strb});
    end
    n_cmp++; if (udo !== 128'h0) begin n_fail++; $display("FAIL mid_ack_udo: got %h want 0", udo); end
    sel = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    bus_op(Base + 12, 1'b0, 32'h0000_00C3, 4'hF, 1, a, rd, st, u);
    model_apply(Base + 12, 1'b0, 32'h0000_00C3, 4'hF, ea, erd, est, eu);
    n_cmp++; if (a !== 1'b1) begin n_fail++; $display("FAIL post_rst_ack: got %b want 1", a); end
    n_cmp++; if (u !== eu) begin n_fail++; $display("FAIL post_rst_udo: got %h want %h", u, eu); end
  endtask

  task automatic test_random();
    logic a, ea, r; logic [31:0] rd, erd, wd, addr; logic [3:0] st, est; logic [0:3] b;
    logic [127:0] u, eu;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        addr = ($urandom_range(0, 1) == 0) ? Base - 32'($urandom_range(1, 64)) :
                                             High + 32'($urandom_range(1, 64));
      end else begin
        addr = Base + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
      end
      r  = 1'($urandom_range(0, 1));
      wd = $urandom;
      b  = 4'($urandom);
      bus_op(addr, r, wd, b, 3, a, rd, st, u);
      model_apply(addr, r, wd, b, ea, erd, est, eu);
      n_cmp++; if (a !== ea) begin n_fail++; $display("FAIL rnd_ack[%0d] %h: got %b want %b", n, addr, a, ea); end
      n_cmp++; if (st !== est) begin n_fail++; $display("FAIL rnd_strb[%0d]: got %b want %b", n, st, est); end
      if (ea) begin
        n_cmp++; if (rd !== erd) begin n_fail++; $display("FAIL rnd_rd[%0d]: got %h want %h", n, rd, erd); end
        n_cmp++; if (u !== eu) begin n_fail++; $display("FAIL rnd_udo_ack[%0d]: got %h want %h", n, u, eu); end
      end
      @(negedge clk);
      n_cmp++; if (udo !== model_udo()) begin
        n_fail++; $display("FAIL rnd_udo_after[%0d]: got %h want %h", n, udo, model_udo());
      end
      n_cmp++; if ({ack, sl_dbus} !== 33'h0) begin
        n_fail++; $display("FAIL rnd_idle[%0d]: got %h want 0", n, {ack, sl_dbus});
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_byte_enables();
    test_pulse();
    test_held_select();
    test_out_of_range();
    test_counter_wrap();
    test_reset_mid_ack();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

endmodule
